// File: rtl/mdu_iter.sv
// Iterative RV M-extension multiply/divide unit.
// Shift-add multiply retiring MUL_BPC multiplier bits per cycle, restoring
// divide retiring one quotient bit per cycle, single-cycle path for divide by
// zero and signed overflow. One op in flight; kill aborts it without a result.
module mdu_iter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_BPC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            strb,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    input  logic            kill,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] res
);

    localparam int unsigned MUL_ITER = XLEN / MUL_BPC;
    localparam int unsigned CNT_W    = $clog2(XLEN);
    localparam int unsigned PW       = XLEN + MUL_BPC;
    localparam int unsigned X2       = 2 * XLEN;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIN,
        S_FAST
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_done;

    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic              r_neg;
    logic              r_sa;
    logic [XLEN-1:0]   r_opa;
    logic [XLEN-1:0]   r_opb;
    logic [X2-1:0]     r_prod;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_fres;

    logic              r_busy;
    logic              r_valid;
    logic [XLEN-1:0]   r_res;

    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_ma;
    logic [XLEN-1:0]   w_mb;
    logic              w_b_zero;
    logic              w_ovf;
    logic              w_fast;
    logic [XLEN-1:0]   w_fres;

    logic [PW-1:0]     w_pp;
    logic [PW-1:0]     w_psum;
    logic [X2-1:0]     w_prod_step;

    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem_step;

    logic [X2-1:0]     w_prod_s;
    logic [XLEN-1:0]   w_quo_s;
    logic [XLEN-1:0]   w_rem_s;
    logic [XLEN-1:0]   w_result;

    // Operand decode at accept: signedness, magnitudes and fast-path result.
    always_comb begin
        w_a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                     (op == OP_DIV) || (op == OP_REM);
        w_b_signed = (op == OP_MUL) || (op == OP_MULH) ||
                     (op == OP_DIV) || (op == OP_REM);
        w_sa       = w_a_signed & a[XLEN-1];
        w_sb       = w_b_signed & b[XLEN-1];
        w_ma       = w_sa ? (XLEN'(0) - a) : a;
        w_mb       = w_sb ? (XLEN'(0) - b) : b;
        w_b_zero   = (b == '0);
        w_ovf      = ((op == OP_DIV) || (op == OP_REM)) &&
                     (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        w_fast     = op[2] && (w_b_zero || w_ovf);
        if (w_b_zero) begin
            w_fres = op[1] ? a : '1;
        end else begin
            w_fres = op[1] ? '0 : a;
        end
    end

    // One multiply step: add multiplicand times the low multiplier digit into
    // the high half, then shift the whole product register right one digit.
    always_comb begin
        w_pp        = PW'(r_opa) * PW'(r_prod[MUL_BPC-1:0]);
        w_psum      = PW'(r_prod[X2-1:XLEN]) + w_pp;
        w_prod_step = X2'({w_psum, r_prod[XLEN-1:0]} >> MUL_BPC);
    end

    // One restoring divide step on an XLEN+1 bit shifted partial remainder.
    always_comb begin
        w_shift    = {r_rem, r_quo[XLEN-1]};
        w_diff     = w_shift - {1'b0, r_opb};
        w_ge       = (w_shift >= {1'b0, r_opb});
        w_rem_step = XLEN'(w_ge ? w_diff : w_shift);
    end

    // Sign fix-up and result select at completion.
    always_comb begin
        w_prod_s = r_neg ? (X2'(0) - r_prod) : r_prod;
        w_quo_s  = r_neg ? (XLEN'(0) - r_quo) : r_quo;
        w_rem_s  = r_sa ? (XLEN'(0) - r_rem) : r_rem;
        w_result = '0;
        if (r_state == S_FAST) begin
            w_result = r_fres;
        end else begin
            case (r_op)
                OP_MUL:                        w_result = w_prod_s[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU:  w_result = w_prod_s[X2-1:XLEN];
                OP_DIV, OP_DIVU:               w_result = w_quo_s;
                OP_REM, OP_REMU:               w_result = w_rem_s;
                default:                       w_result = '0;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; kill aborts any busy state and blocks a new accept.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (strb && !kill) begin
                    w_accept = 1'b1;
                    if (w_fast) begin
                        w_state_nxt = S_FAST;
                    end else if (op[2]) begin
                        w_state_nxt = S_DIV;
                    end else begin
                        w_state_nxt = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (kill) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_W'(MUL_ITER - 1)) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_DIV: begin
                if (kill) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_W'(XLEN - 1)) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN, S_FAST: begin
                w_state_nxt = S_IDLE;
                w_done      = !kill;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered handshake outputs and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_res   <= '0;
        end else begin
            r_busy  <= (w_state_nxt != S_IDLE);
            r_valid <= w_done;
            if (w_done) begin
                r_res <= w_result;
            end
        end
    end

    // Datapath: capture operands on accept, then iterate in MUL/DIV.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op   <= op;
            r_neg  <= w_sa ^ w_sb;
            r_sa   <= w_sa;
            r_opa  <= w_ma;
            r_opb  <= w_mb;
            r_prod <= {XLEN'(0), w_mb};
            r_quo  <= w_ma;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_fres <= w_fres;
        end else if (r_state == S_MUL) begin
            r_prod <= w_prod_step;
            r_cnt  <= r_cnt + CNT_W'(1);
        end else if (r_state == S_DIV) begin
            r_quo  <= {r_quo[XLEN-2:0], w_ge};
            r_rem  <= w_rem_step;
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    assign busy  = r_busy;
    assign valid = r_valid;
    assign res   = r_res;

endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter: vector table and random ops through a scoreboard,
// plus hand-written kill/reset/strobe-timing sequences.
module tb_mdu_iter;

    localparam int unsigned XLEN = 32;

    logic            clk  = 1'b0;
    logic            rst  = 1'b1;
    logic            strb = 1'b0;
    logic            kill = 1'b0;
    logic [XLEN-1:0] a    = '0;
    logic [XLEN-1:0] b    = '0;
    logic [2:0]      op   = 3'd0;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] res;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          ev;
    } sb_t;

    sb_t  sbq[$];
    vec_t vt[21];
    int   edge_n = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    mdu_iter #(.XLEN(32), .MUL_BPC(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .strb  (strb),
        .a     (a),
        .b     (b),
        .op    (op),
        .kill  (kill),
        .busy  (busy),
        .valid (valid),
        .res   (res)
    );

    always #5 clk = ~clk;

    // Edge counter used for latency checks.
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_n);
    endtask

    // Independent reference using native 64-bit and signed arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0]        p;
        logic signed [63:0] sp;
        logic [31:0]        r;
        r = '0;
        case (o)
            3'd0: begin p = 64'(x) * 64'(y); r = p[31:0]; end
            3'd1: begin sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); r = sp[63:32]; end
            3'd2: begin sp = $signed({{32{x[31]}}, x}) * $signed({32'b0, y}); r = sp[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
            3'd4: begin
                if (y == 0) r = '1;
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = x;
                else r = 32'($signed(x) / $signed(y));
            end
            3'd5: r = (y == 0) ? 32'hFFFFFFFF : x / y;
            3'd6: begin
                if (y == 0) r = x;
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = '0;
                else r = 32'($signed(x) % $signed(y));
            end
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    function automatic int lat_of(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && (y == 0 || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))) return 1;
        return o[2] ? 33 : 17;
    endfunction

    // Scoreboard consumer: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        sb_t e;
        if (valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", 32'(res), 32'hDEADBEEF ^ 32'(res) ^ 32'hDEADBEEF ^ 32'd1 ^ 32'(res));
            end else begin
                e = sbq.pop_front();
                chk("res", res, e.res);
                chk("latency", 32'(edge_n), 32'(e.ev));
                chk("busy_in_valid", 32'(busy), 32'd0);
            end
        end
    end

    // Issue one op as soon as the unit is free; optionally expect a result.
    task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e, input int lat, input bit push);
        int t;
        sb_t s;
        t = 0;
        while (busy !== 1'b0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("send_timeout", 32'd1, 32'd0);
        op   = o;
        a    = x;
        b    = y;
        strb = 1'b1;
        if (push) begin
            s.res = e;
            s.ev  = edge_n + 1 + lat;
            sbq.push_back(s);
        end
        @(negedge clk);
        strb = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(sbq.size()), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        bit          seen;

        vt[0]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vt[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vt[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vt[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vt[4]  = '{3'd0, 32'h00012345, 32'h00000100, 32'h01234500};
        vt[5]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD};
        vt[6]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF};
        vt[7]  = '{3'd5, 32'd100,      32'd7,        32'd14};
        vt[8]  = '{3'd7, 32'd100,      32'd7,        32'd2};
        vt[9]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF};
        vt[10] = '{3'd7, 32'd5,        32'd0,        32'd5};
        vt[11] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vt[12] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        vt[13] = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
        vt[14] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'h00000001};
        vt[15] = '{3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF};
        vt[16] = '{3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB};
        vt[17] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
        vt[18] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vt[19] = '{3'd3, 32'h80000000, 32'h00000002, 32'h00000001};
        vt[20] = '{3'd4, 32'h80000000, 32'h00000001, 32'h80000000};

        // Reset with a strobe pending: reset must win.
        strb = 1'b1; op = 3'd5; a = 32'd5; b = 32'd0;
        repeat (2) @(negedge clk);
        strb = 1'b0;
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_res",   res,        32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_strb_dropped", 32'(busy), 32'd0);

        // Directed vectors, issued back-to-back in each valid cycle.
        for (int i = 0; i < 21; i++)
            send(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, lat_of(vt[i].op, vt[i].a, vt[i].b), 1'b1);
        drain();

        // Strobe and operand changes while busy are ignored.
        send(3'd0, 32'd3, 32'd5, 32'd15, 17, 1'b1);
        repeat (3) @(negedge clk);
        op = 3'd4; a = 32'd99; b = 32'd3; strb = 1'b1;
        @(negedge clk);
        strb = 1'b0;
        drain();

        // Kill a divide at iteration 5, then restart immediately.
        send(3'd4, 32'd1000, 32'd3, 32'd0, 33, 1'b0);
        repeat (4) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy", 32'(busy), 32'd0);
        send(3'd5, 32'd9, 32'd3, 32'd3, 33, 1'b1);
        drain();

        // Kill together with strobe: strobe dropped.
        op = 3'd5; a = 32'd9; b = 32'd3; strb = 1'b1; kill = 1'b1;
        @(negedge clk);
        strb = 1'b0; kill = 1'b0;
        chk("kill_strb_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);

        // Kill in the valid cycle: pulse kept, coincident strobe dropped.
        send(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            if (valid === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        chk("fast_valid_seen", 32'(seen), 32'd1);
        kill = 1'b1; strb = 1'b1; op = 3'd5; a = 32'd9; b = 32'd3;
        @(negedge clk);
        kill = 1'b0; strb = 1'b0;
        chk("kill_valid_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);

        // Random ops against the reference model.
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = (i % 6 == 0) ? 32'd0 : ((i % 4 == 1) ? 32'($urandom_range(1, 300)) : $urandom);
            send(o, x, y, ref_res(o, x, y), lat_of(o, x, y), 1'b1);
        end
        drain();
        send(3'd0, 32'd6, 32'd7, 32'd42, 17, 1'b1);
        drain();

        // Reset in the middle of a multiply: no result, outputs cleared.
        send(3'd0, 32'd3, 32'd5, 32'd0, 17, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy",  32'(busy),  32'd0);
        chk("rst_mid_valid", 32'(valid), 32'd0);
        chk("rst_mid_res",   res,        32'd0);
        repeat (30) @(negedge clk);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
